e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//  Multiply/divide unit alongside the E-stage ALU of the 5-stage MIPS pipeline.
//  Executes MULT/MULTU/DIV/DIVU with a fixed multi-cycle latency and MTHI/MTLO in a single cycle.
//  Holds the architectural HI/LO registers, which feed MFHI/MFLO in E.
//  Provides stall_req so the hazard unit holds a D-stage MDU instruction while a prior op is in flight.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk        in   1   rising-edge clock
//  reset      in   1   asynchronous, active-high reset
//  start      in   1   E-stage instr is an MDU op; sampled on rising edge
//  mdu_op     in   3   0 NONE,1 MULT,2 MULTU,3 DIV,4 DIVU,5 MTHI,6 MTLO,7 rsvd(=NONE)
//  src_a      in   32  forwarded rs value
//  src_b      in   32  forwarded rt value
//  busy       out  1   multi-cycle op in flight
//  stall_req  out  1   comb: busy | (start & mdu_op in 1..4)
//  hi         out  32  HI register (MFHI source)
//  lo         out  32  LO register (MFLO source)
// BEHAVIOUR
//  - Reset (async, any time): hi=0, lo=0, busy=0, counter=0, pending result discarded.
//  - Accept: op taken at an edge where start=1 and busy=0. When busy=1, start is ignored
//    (no HI/LO change, no restart). The hazard unit guarantees this case does not occur.
//  - MULT/MULTU at accept edge:
//    - Compute 64-bit product of src_a*src_b, signed for MULT, unsigned for MULTU.
//    - Latch product in tmp_hi/tmp_lo; counter<=MULT_CYCLES; busy<=1.
//  - DIV/DIVU at accept edge:
//    - tmp_lo = quotient, tmp_hi = remainder; counter<=DIV_CYCLES; busy<=1.
//    - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
//    - 0x80000000 / 0xFFFFFFFF (signed): tmp_lo=0x80000000, tmp_hi=0.
//    - src_b==0: op still occupies DIV_CYCLES, but hi/lo are left unchanged at completion.
//  - While busy: counter decrements each edge. At the edge where counter==1:
//    hi<=tmp_hi, lo<=tmp_lo, busy<=0, counter<=0.
//    - busy is high for exactly N cycles (MULT_CYCLES or DIV_CYCLES).
//    - New hi/lo are visible the cycle busy falls.
//  - MTHI/MTLO at accept edge: hi<=src_a (MTHI) or lo<=src_a (MTLO); no busy; other register unchanged.
//  - NONE/rsvd with start=1: no state change.
//  - hi/lo are plain register outputs; MFHI in the same cycle as an MTHI accept sees the old value
//    (forwarding is the hazard unit's job).
//  - Back-to-back: a new op may be accepted on the edge right after busy falls. Pipeline throughput
//    is 1 MDU op per N+1 cycles worst case.
//  - stall_req is purely combinational from start, mdu_op and busy.
//  - An MT*/NONE with start=1 does not raise stall_req unless busy=1.
//  - All arithmetic is 32-bit in, 64-bit intermediate; no overflow traps.
// TESTING
//  1. MULT src_a=0xFFFFFFFD(-3), src_b=5 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFF1.
//  2. MULTU 0xFFFFFFFF*2 -> hi=0x00000001, lo=0xFFFFFFFE; DIVU 17/5 -> busy 10 cycles, lo=3, hi=2.
//  3. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
//     DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
//  4. Preload hi=0x11,lo=0x22 via MTHI/MTLO, then DIV x/0 -> busy 10 cycles, hi=0x11, lo=0x22 after.
//  5. MULT accepted, then start=1 MTLO src_a=0xAB on busy cycle 2 -> ignored.
//     stall_req=1 throughout busy; final lo is the product, not 0xAB.
//  6. DIVU accepted, reset pulsed on busy cycle 4 (between edges) -> busy=0, hi=lo=0 immediately.
//     No late write after reset releases.

Source files
------------

// File: rtl/e_mdu.sv
// Multiply/divide unit beside the E-stage ALU: multi-cycle MULT/MULTU/DIV/DIVU,
// single-cycle MTHI/MTLO, and the architectural HI/LO registers.
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  mdu_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } mdu_op_e;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  // 64-bit product; operands are sign- or zero-extended so truncation is exact.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
    eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  // Returns {remainder, quotient}; signed form truncates toward zero and the
  // remainder follows the dividend's sign. A zero divisor yields zero (never written).
  function automatic logic [63:0] div64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] ua;
    logic [31:0] ub;
    logic [31:0] q;
    logic [31:0] r;
    ua = (sgn && a[31]) ? (32'd0 - a) : a;
    ub = (sgn && b[31]) ? (32'd0 - b) : b;
    if (ub == 32'd0) begin
      q = 32'd0;
      r = 32'd0;
    end else begin
      q = ua / ub;
      r = ua % ub;
    end
    if (sgn && (a[31] ^ b[31])) q = 32'd0 - q;
    if (sgn && a[31])           r = 32'd0 - r;
    return {r, q};
  endfunction

  logic [31:0]   hi_r;
  logic [31:0]   lo_r;
  logic [31:0]   tmp_hi_r;
  logic [31:0]   tmp_lo_r;
  logic          busy_r;
  logic          wr_en_r;
  logic [CW-1:0] cnt_r;
  logic [63:0]   mul_s;
  logic [63:0]   div_s;
  logic          long_op_s;

  // Arithmetic results and long-op decode from the current operands.
  always_comb begin
    mul_s     = mul64(src_a, src_b, mdu_op == OP_MULT);
    div_s     = div64(src_a, src_b, mdu_op == OP_DIV);
    long_op_s = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU) ||
                (mdu_op == OP_DIV)  || (mdu_op == OP_DIVU);
  end

  assign stall_req = busy_r | (start & long_op_s);
  assign busy      = busy_r;
  assign hi        = hi_r;
  assign lo        = lo_r;

  // Op acceptance, busy countdown and HI/LO commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      tmp_hi_r <= 32'd0;
      tmp_lo_r <= 32'd0;
      busy_r   <= 1'b0;
      wr_en_r  <= 1'b0;
      cnt_r    <= '0;
    end else if (busy_r) begin
      if (cnt_r == CW'(1)) begin
        if (wr_en_r) begin
          hi_r <= tmp_hi_r;
          lo_r <= tmp_lo_r;
        end
        busy_r <= 1'b0;
        cnt_r  <= '0;
      end else begin
        cnt_r <= cnt_r - CW'(1);
      end
    end else if (start) begin
      case (mdu_op)
        OP_MULT, OP_MULTU: begin
          tmp_hi_r <= mul_s[63:32];
          tmp_lo_r <= mul_s[31:0];
          wr_en_r  <= 1'b1;
          busy_r   <= 1'b1;
          cnt_r    <= CW'(MULT_CYCLES);
        end
        OP_DIV, OP_DIVU: begin
          tmp_hi_r <= div_s[63:32];
          tmp_lo_r <= div_s[31:0];
          wr_en_r  <= (src_b != 32'd0);
          busy_r   <= 1'b1;
          cnt_r    <= CW'(DIV_CYCLES);
        end
        OP_MTHI: hi_r <= src_a;
        OP_MTLO: lo_r <= src_a;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_e_mdu.sv
// Directed self-checking bench for e_mdu with hand-computed HI/LO results.
module tb_e_mdu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  mdu_op = 3'd0;
  logic [31:0] src_a = 32'd0;
  logic [31:0] src_b = 32'd0;
  logic        busy;
  logic        stall_req;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .mdu_op(mdu_op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .stall_req(stall_req),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Caller sits at a negedge; the op is accepted on the following posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start  = 1'b1;
    mdu_op = op;
    src_a  = a;
    src_b  = b;
    @(negedge clk);
    start  = 1'b0;
    mdu_op = 3'd0;
  endtask

  // Issue an op and count negedges with busy high (bounded); returns at the negedge busy is low.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int cycles);
    issue(op, a, b);
    cycles = 0;
    while (busy === 1'b1 && cycles < 50) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL reset_hi got %h want 0", hi); end
    n_checks++; if (lo !== 32'd0) begin n_fail++; $display("FAIL reset_lo got %h want 0", lo); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall got %0b want 0", stall_req); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult;
    int c;
    run_op(3'd1, 32'hFFFF_FFFD, 32'd5, c);
    n_checks++; if (c !== 5) begin n_fail++; $display("FAIL mult_busy_cycles got %0d want 5", c); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", hi); end
    n_checks++; if (lo !== 32'hFFFF_FFF1) begin n_fail++; $display("FAIL mult_lo got %h want fffffff1", lo); end
  endtask

  // Ops issued on the very negedge busy falls exercise back-to-back acceptance.
  task automatic test_back_to_back;
    int c;
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, c);
    n_checks++; if (c !== 5) begin n_fail++; $display("FAIL multu_busy_cycles got %0d want 5", c); end
    n_checks++; if ({hi, lo} !== 64'h0000_0001_FFFF_FFFE) begin n_fail++; $display("FAIL multu_hilo got %h%h want 00000001fffffffe", hi, lo); end
    run_op(3'd4, 32'd17, 32'd5, c);
    n_checks++; if (c !== 10) begin n_fail++; $display("FAIL divu_busy_cycles got %0d want 10", c); end
    n_checks++; if (lo !== 32'd3) begin n_fail++; $display("FAIL divu_lo got %h want 3", lo); end
    n_checks++; if (hi !== 32'd2) begin n_fail++; $display("FAIL divu_hi got %h want 2", hi); end
  endtask

  task automatic test_div_signed;
    int c;
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, c);
    n_checks++; if (c !== 10) begin n_fail++; $display("FAIL div_busy_cycles got %0d want 10", c); end
    n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg_lo got %h want fffffffd", lo); end
    n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg_hi got %h want ffffffff", hi); end
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, c);
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf_lo got %h want 80000000", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL div_ovf_hi got %h want 0", hi); end
  endtask

  task automatic test_mt_and_div0;
    int c;
    // Before the accept edge the old HI is still visible and no stall is raised.
    start = 1'b1; mdu_op = 3'd5; src_a = 32'h11; src_b = 32'd0;
    #1;
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL mthi_old_hi got %h want 0", hi); end
    n_checks++; if (stall_req !== 1'b0) begin n_fail++; $display("FAIL mthi_no_stall got %0b want 0", stall_req); end
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (hi !== 32'h11) begin n_fail++; $display("FAIL mthi_hi got %h want 11", hi); end
    n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL mthi_lo_kept got %h want 80000000", lo); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mthi_busy got %0b want 0", busy); end
    issue(3'd6, 32'h22, 32'd0);
    n_checks++; if (lo !== 32'h22) begin n_fail++; $display("FAIL mtlo_lo got %h want 22", lo); end
    n_checks++; if (hi !== 32'h11) begin n_fail++; $display("FAIL mtlo_hi_kept got %h want 11", hi); end
    issue(3'd0, 32'h99, 32'd1);
    issue(3'd7, 32'h99, 32'd1);
    n_checks++; if ({busy, hi, lo} !== {1'b0, 32'h11, 32'h22}) begin n_fail++; $display("FAIL none_rsvd got %0b %h %h want 0 11 22", busy, hi, lo); end
    start = 1'b1; mdu_op = 3'd3;
    #1;
    n_checks++; if (stall_req !== 1'b1) begin n_fail++; $display("FAIL start_div_stall got %0b want 1", stall_req); end
    start = 1'b0; mdu_op = 3'd0;
    @(negedge clk);
    run_op(3'd3, 32'd1234, 32'd0, c);
    n_checks++; if (c !== 10) begin n_fail++; $display("FAIL div0_busy_cycles got %0d want 10", c); end
    n_checks++; if (hi !== 32'h11) begin n_fail++; $display("FAIL div0_hi got %h want 11", hi); end
    n_checks++; if (lo !== 32'h22) begin n_fail++; $display("FAIL div0_lo got %h want 22", lo); end
  endtask

  task automatic test_ignore_while_busy;
    int c;
    int stall_low;
    issue(3'd1, 32'd7, 32'd6);
    stall_low = 0;
    c = 0;
    while (busy === 1'b1 && c < 50) begin
      c++;
      if (c == 2) begin
        start = 1'b1; mdu_op = 3'd6; src_a = 32'hAB;
      end else begin
        start = 1'b0; mdu_op = 3'd0;
      end
      #1;
      if (stall_req !== 1'b1) stall_low++;
      @(negedge clk);
    end
    start = 1'b0; mdu_op = 3'd0;
    n_checks++; if (c !== 5) begin n_fail++; $display("FAIL ignore_busy_cycles got %0d want 5", c); end
    n_checks++; if (stall_low !== 0) begin n_fail++; $display("FAIL ignore_stall_low got %0d want 0", stall_low); end
    n_checks++; if (lo !== 32'd42) begin n_fail++; $display("FAIL ignore_lo got %h want 2a", lo); end
    n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL ignore_hi got %h want 0", hi); end
  endtask

  task automatic test_reset_mid_op;
    int late;
    issue(3'd4, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    n_checks++; if ({busy, hi, lo} !== 65'd0) begin n_fail++; $display("FAIL midreset_state got %0b %h %h want 0 0 0", busy, hi, lo); end
    #1;
    reset = 1'b0;
    late = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) late++;
    end
    n_checks++; if (late !== 0) begin n_fail++; $display("FAIL midreset_late_write got %0d want 0", late); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_back_to_back;
    test_div_signed;
    test_mt_and_div0;
    test_ignore_while_busy;
    test_reset_mid_op;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
